clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
- Programmable, glitch-free controller for the slow clock dividers (e.g. the 250 Hz condition clock).
- Starts and stops the divided clock cleanly on phase boundaries.
- Accepts divide-ratio changes from a configuring master through a REQ/ACK handshake and applies each change only at a period boundary, so no runt pulses reach downstream logic.

Parameters:
- CNT_W, 5, width of the half-period counter and of CFG_HALF.
- DEFAULT_HALF, 8, half-period in CLK cycles loaded at reset. 8 gives a period of 16 CLK cycles.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous, active-low reset.
- EN  input  1  run request (level).
- CFG_REQ  input  1  configuration request (level, held until CFG_ACK).
- CFG_HALF  input  CNT_W  new half-period; stable while CFG_REQ=1.
- CFG_ACK  output  1  one-cycle pulse: new half-period applied.
- CLK_OUT  output  1  divided clock, registered.
- TICK  output  1  one-cycle pulse on each CLK_OUT rising edge.
- BUSY  output  1  1 when not in IDLE.

Behaviour:
- Reset (RESET=0, async): state=IDLE, counter=0, half=DEFAULT_HALF, pending=0, ack_done=0. All outputs are 0. Reset mid-operation drops CLK_OUT to 0 immediately; there is no graceful stop.
- States: IDLE, RUN_LO, RUN_HI. The counter runs 0..half-1 in both RUN states.
- IDLE:
  - CLK_OUT=0 and counter held at 0.
  - EN=1 sampled at edge t moves to RUN_LO with counter=0.
  - With half=8, CLK_OUT rises at edge t+8.
- RUN_LO:
  - counter+1 each edge.
  - When counter==half-1 and EN=1: CLK_OUT<=1, TICK<=1 for that one cycle, counter<=0, go to RUN_HI.
  - When counter==half-1 and EN=0: stay low, counter<=0, go to IDLE.
  - EN is checked only at the phase end.
- RUN_HI:
  - counter+1 each edge.
  - When counter==half-1: CLK_OUT<=0, counter<=0, apply any pending config.
  - Then go to RUN_LO if EN=1, else IDLE.
  - A high phase always completes its full length, even if EN drops.
- Result: a duty cycle of exactly 50%, period 2*half.
- Config handshake:
  - On CFG_REQ=1 with pending=0 and ack_done=0, latch CFG_HALF into pend_half and set pending=1.
  - Application point: in IDLE, the next edge after latching; while running, the RUN_HI→low transition edge only.
  - On application: half<=pend_half, pending<=0, ack_done<=1, and CFG_ACK=1 for exactly one cycle (the cycle following the application edge).
  - ack_done clears when CFG_REQ=0. This prevents re-triggering while the master is still holding REQ.
  - CFG_HALF changes while pending=1 are ignored; the latched value wins.
- Width rules:
  - CFG_HALF=0 is clamped to 1 at latch, giving period 2 (CLK/2).
  - Maximum half is 2^CNT_W-1.
  - The counter compare is unsigned and never wraps past half-1.
- Simultaneous events:
  - An EN drop and a config application at the same RUN_HI end: the config is applied, then the block enters IDLE with the new half.
  - A CFG_REQ rising in the same cycle as EN rising in IDLE: EN takes priority. RUN_LO starts with the old half, and the config applies at the first RUN_HI end.
- BUSY equals (state != IDLE).

Decomposition:
- Shared package clk_div_pkg:
  - state encoding IDLE/RUN_LO/RUN_HI;
  - DEFAULT_HALF;
  - CNT_W;
  - the clamp-to-minimum constant MIN_HALF=1.
- Sub-module clk_div_core: the half-period counter plus CLK_OUT/TICK registers.
  - Driven by run/half inputs.
  - Outputs a phase_end strobe.
- clk_div_ctrl holds the FSM, the config latch and the handshake.

Test Plan:
- Reset release, EN=1 held, half=8 → first CLK_OUT rise 8 edges after EN sampled, then period 16 (8 high/8 low); TICK is one cycle per rise; BUSY=1.
- Running at half=8, CFG_REQ with CFG_HALF=4 asserted mid-RUN_LO → no change until the end of the next high phase; CFG_ACK pulses once; following periods are 8 (4/4); holding REQ after ACK produces no second ACK.
- EN dropped 2 cycles into a high phase (half=8) → CLK_OUT stays high 6 more cycles, falls, state=IDLE, BUSY=0, CLK_OUT remains 0.
- In IDLE, CFG_REQ with CFG_HALF=0 → CFG_ACK next-after-apply cycle, half=1; then EN=1 → CLK_OUT toggles every cycle (period 2).
- RESET asserted mid-high phase with a config pending → CLK_OUT, TICK, CFG_ACK and BUSY go to 0 asynchronously; after release, half=8 and the pending config is discarded.
- EN drop coinciding with the config apply edge → ACK pulses, IDLE is entered; next EN start uses the new half.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the glitch-free slow clock divider controller.
package clk_div_pkg;

    localparam int CNT_W        = 5;
    localparam int DEFAULT_HALF = 8;
    localparam int MIN_HALF     = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_LO = 2'd1,
        RUN_HI = 2'd2
    } state_t;

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter with the registered divided clock and its rising-edge tick.
module clk_div_core #(
    parameter int W = clk_div_pkg::CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    input  logic         set_hi,
    input  logic         set_lo,
    input  logic [W-1:0] half,
    output logic         phase_end,
    output logic         clk_out,
    output logic         tick
);

    logic [W-1:0] count;

    // half is never below 1, so half-1 cannot underflow and count never passes it
    assign phase_end = run && (count == (half - W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick <= set_hi;
            if (set_hi) begin
                clk_out <= 1'b1;
            end else if (set_lo) begin
                clk_out <= 1'b0;
            end
            if (!run || phase_end) begin
                count <= '0;
            end else begin
                count <= count + W'(1);
            end
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run/stop FSM, configuration latch and REQ/ACK handshake around clk_div_core.
module clk_div_ctrl #(
    parameter int CNT_W        = clk_div_pkg::CNT_W,
    parameter int DEFAULT_HALF = clk_div_pkg::DEFAULT_HALF
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                EN,
    input  logic                CFG_REQ,
    input  logic [CNT_W-1:0]    CFG_HALF,
    output logic                CFG_ACK,
    output logic                CLK_OUT,
    output logic                TICK,
    output logic                BUSY,
    output clk_div_pkg::state_t dbg_state,
    output logic [CNT_W-1:0]    dbg_half
);
    import clk_div_pkg::*;

    localparam logic [CNT_W-1:0] HALF_MIN = CNT_W'(MIN_HALF);
    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] pend_half;
    logic             pending;
    logic             ack_done;
    logic             phase_end;
    logic             run;
    logic             set_hi;
    logic             set_lo;
    logic             apply;

    assign run       = (state != IDLE);
    assign BUSY      = run;
    assign dbg_state = state;
    assign dbg_half  = half;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // EN only matters in IDLE and at phase ends; a high phase always completes.
    always_comb begin
        next_state = state;
        set_hi     = 1'b0;
        set_lo     = 1'b0;
        case (state)
            IDLE: begin
                if (EN) next_state = RUN_LO;
            end
            RUN_LO: begin
                if (phase_end) begin
                    if (EN) begin
                        next_state = RUN_HI;
                        set_hi     = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            RUN_HI: begin
                if (phase_end) begin
                    set_lo     = 1'b1;
                    next_state = EN ? RUN_LO : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Handshake: the master raises CFG_REQ with CFG_HALF stable and holds both
    // until CFG_ACK; the value is latched once, applied only in IDLE or at the
    // end of a high phase, acknowledged by a one-cycle CFG_ACK, and no new
    // request is accepted until CFG_REQ has been seen low again.
    assign apply = pending && ((state == IDLE) || ((state == RUN_HI) && phase_end));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            half      <= HALF_RST;
            pend_half <= '0;
            pending   <= 1'b0;
            ack_done  <= 1'b0;
            CFG_ACK   <= 1'b0;
        end else begin
            CFG_ACK <= apply;
            if (apply) begin
                half     <= pend_half;
                pending  <= 1'b0;
                ack_done <= 1'b1;
            end else begin
                if (!CFG_REQ) ack_done <= 1'b0;
                if (CFG_REQ && !pending && !ack_done) begin
                    pending   <= 1'b1;
                    pend_half <= (CFG_HALF < HALF_MIN) ? HALF_MIN : CFG_HALF;
                end
            end
        end
    end

    clk_div_core #(.W(CNT_W)) u_core (
        .clk       (CLK),
        .rst_n     (RESET),
        .run       (run),
        .set_hi    (set_hi),
        .set_lo    (set_lo),
        .half      (half),
        .phase_end (phase_end),
        .clk_out   (CLK_OUT),
        .tick      (TICK)
    );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: tick-cycle scoreboard plus point checks.
module tb_clk_div_ctrl;
    import clk_div_pkg::*;

    logic                CLK = 1'b0;
    logic                RESET = 1'b1;
    logic                EN = 1'b0;
    logic                CFG_REQ = 1'b0;
    logic [CNT_W-1:0]    CFG_HALF = '0;
    logic                CFG_ACK;
    logic                CLK_OUT;
    logic                TICK;
    logic                BUSY;
    state_t              dbg_state;
    logic [CNT_W-1:0]    dbg_half;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int ack_cnt = 0;
    logic [31:0] exp_q[$];

    clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_HALF(DEFAULT_HALF)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .EN        (EN),
        .CFG_REQ   (CFG_REQ),
        .CFG_HALF  (CFG_HALF),
        .CFG_ACK   (CFG_ACK),
        .CLK_OUT   (CLK_OUT),
        .TICK      (TICK),
        .BUSY      (BUSY),
        .dbg_state (dbg_state),
        .dbg_half  (dbg_half)
    );

    // clock / reset-independent edge counter
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge CLK);
    endtask

    // scoreboard: every TICK must match the next expected edge number
    always @(negedge CLK) begin
        if (CFG_ACK) ack_cnt++;
        if (TICK) begin
            if (exp_q.size() > 0) begin
                chk("tick_cycle", cyc, exp_q.pop_front());
            end else begin
                checks++;
                errors++;
                $error("FAIL tick_unexpected observed=%0d expected=none", cyc);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int s;
        int v;
        int w;
        int x;

        // asynchronous reset
        #1 RESET = 1'b0;
        #1;
        chk("rst_clk_out", CLK_OUT, 0);
        chk("rst_tick", TICK, 0);
        chk("rst_ack", CFG_ACK, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_state", dbg_state, IDLE);
        chk("rst_half", dbg_half, 8);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);

        // start at half=8, then drop EN two cycles into a high phase
        t = cyc + 1;
        EN = 1'b1;
        exp_q.push_back(t + 8);
        exp_q.push_back(t + 24);
        exp_q.push_back(t + 40);
        wait_until(t + 1);
        chk("run_busy", BUSY, 1);
        wait_until(t + 7);
        chk("first_low", CLK_OUT, 0);
        wait_until(t + 8);
        chk("first_rise", CLK_OUT, 1);
        wait_until(t + 9);
        chk("tick_width", TICK, 0);
        wait_until(t + 15);
        chk("hi_8_end", CLK_OUT, 1);
        wait_until(t + 16);
        chk("hi_8_fall", CLK_OUT, 0);
        wait_until(t + 41);
        EN = 1'b0;
        wait_until(t + 47);
        chk("stop_hi_held", CLK_OUT, 1);
        wait_until(t + 48);
        chk("stop_fall", CLK_OUT, 0);
        chk("stop_busy", BUSY, 0);
        chk("stop_state", dbg_state, IDLE);
        wait_until(t + 52);
        chk("stop_stays_low", CLK_OUT, 0);

        // restart, change to half=4 mid low phase; applies at next high end
        s = cyc + 1;
        EN = 1'b1;
        exp_q.push_back(s + 8);
        exp_q.push_back(s + 24);
        wait_until(s + 18);
        CFG_REQ = 1'b1;
        CFG_HALF = 5'd4;
        exp_q.push_back(s + 36);
        exp_q.push_back(s + 44);
        exp_q.push_back(s + 52);
        wait_until(s + 25);
        CFG_HALF = 5'd7;
        wait_until(s + 31);
        chk("cfg_ack_early", CFG_ACK, 0);
        chk("cfg_half_early", dbg_half, 8);
        wait_until(s + 32);
        chk("cfg_ack_pulse", CFG_ACK, 1);
        chk("cfg_half_new", dbg_half, 4);
        wait_until(s + 33);
        chk("cfg_ack_one", CFG_ACK, 0);
        wait_until(s + 39);
        chk("hi_4_end", CLK_OUT, 1);
        wait_until(s + 40);
        chk("hi_4_fall", CLK_OUT, 0);
        wait_until(s + 50);
        chk("no_reack", ack_cnt, 1);
        CFG_REQ = 1'b0;

        // config apply coinciding with EN drop at the high phase end
        wait_until(s + 53);
        CFG_REQ = 1'b1;
        CFG_HALF = 5'd6;
        wait_until(s + 55);
        EN = 1'b0;
        wait_until(s + 56);
        chk("coin_ack", CFG_ACK, 1);
        chk("coin_half", dbg_half, 6);
        chk("coin_state", dbg_state, IDLE);
        chk("coin_clk_out", CLK_OUT, 0);
        wait_until(s + 57);
        CFG_REQ = 1'b0;
        wait_until(s + 60);
        v = cyc + 1;
        EN = 1'b1;
        exp_q.push_back(v + 6);
        exp_q.push_back(v + 18);
        wait_until(v + 11);
        chk("hi_6_end", CLK_OUT, 1);
        wait_until(v + 12);
        chk("hi_6_fall", CLK_OUT, 0);

        // reset mid high phase with a config pending
        wait_until(v + 19);
        CFG_REQ = 1'b1;
        CFG_HALF = 5'd3;
        wait_until(v + 21);
        chk("pre_rst_hi", CLK_OUT, 1);
        #2 RESET = 1'b0;
        #1;
        chk("arst_clk_out", CLK_OUT, 0);
        chk("arst_tick", TICK, 0);
        chk("arst_ack", CFG_ACK, 0);
        chk("arst_busy", BUSY, 0);
        chk("arst_half", dbg_half, 8);
        CFG_REQ = 1'b0;
        EN = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        wait_until(v + 27);
        chk("discard_acks", ack_cnt, 2);
        chk("discard_half", dbg_half, 8);
        chk("discard_state", dbg_state, IDLE);

        // CFG_HALF=0 clamps to 1 in IDLE, then run at CLK/2
        w = cyc;
        CFG_REQ = 1'b1;
        CFG_HALF = 5'd0;
        wait_until(w + 1);
        chk("idle_ack_wait", CFG_ACK, 0);
        wait_until(w + 2);
        chk("clamp_ack", CFG_ACK, 1);
        chk("clamp_half", dbg_half, 1);
        wait_until(w + 3);
        CFG_REQ = 1'b0;
        wait_until(w + 5);
        x = cyc;
        EN = 1'b1;
        for (int i = 1; i <= 4; i++) exp_q.push_back(x + 2 * i);
        wait_until(x + 2);
        chk("div2_hi0", CLK_OUT, 1);
        wait_until(x + 3);
        chk("div2_lo0", CLK_OUT, 0);
        wait_until(x + 4);
        chk("div2_hi1", CLK_OUT, 1);
        wait_until(x + 8);
        EN = 1'b0;
        wait_until(x + 12);
        chk("end_state", dbg_state, IDLE);
        chk("end_clk_out", CLK_OUT, 0);
        chk("end_acks", ack_cnt, 3);
        chk("ticks_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
